hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max consecutive data-memory wait cycles before error.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ID_mux_sel  in  12  decoded ID controls; [11:9] branch select, `DONT_BRANCH = no branch.
REQ-005 SHALL have ports: ID_valid  in  1;  ID_rs1, ID_rs2  in  5;  ID_uses_rs1, ID_uses_rs2  in  1  source-operand info of ID instruction.
REQ-006 SHALL have ports: EX_rd  in  5;  EX_is_load  in  1  destination and load flag of EX instruction.
REQ-007 SHALL have ports: EX_br_resolved  in  1  branch in EX has computed its target/decision this cycle.
REQ-008 SHALL have ports: MEM_req  in  1;  MEM_ack  in  1  data-memory request/acknowledge for MEM instruction.
REQ-009 SHALL have outputs: ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en  out  1  pipeline-register enables.
REQ-010 SHALL have outputs: ST_br_stall  out  1  suppress PC update;  ST_if_id_flush  out  1  load NOP into IF/ID;  ST_id_ex_bubble  out  1  load NOP into ID/EX.
REQ-011 SHALL have output ST_mem_err  out  1  one-cycle pulse on memory timeout.

Function
REQ-012 SHALL implement FSM with states RUN and BR_WAIT, plus 4-bit wait counter wcnt.
REQ-013 SHALL define freeze = MEM_req & ~MEM_ack & (wcnt < MEM_TIMEOUT); while freeze, all four enables 0, flush/bubble 0, ST_br_stall 1, FSM state and branch detection held.
REQ-014 SHALL increment wcnt each freeze cycle, clear it on any non-freeze cycle; if MEM_req & ~MEM_ack with wcnt == MEM_TIMEOUT, pulse ST_mem_err, clear wcnt, release pipeline that cycle.
REQ-015 SHALL, in RUN without freeze, detect load-use: EX_is_load & EX_rd!=0 & ID_valid & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)); then ST_if_id_en=0, ST_br_stall=1, ST_id_ex_bubble=1 for that cycle only (combinational, zero latency).
REQ-016 SHALL, in RUN without freeze or load-use, on ID_valid & ID_mux_sel[11:9]!=`DONT_BRANCH assert ST_br_stall=1 same cycle and enter BR_WAIT next edge.
REQ-017 SHALL, in BR_WAIT, assert ST_br_stall=1 and ST_if_id_flush=1; return to RUN on the edge where EX_br_resolved=1 (ST_br_stall drops the following cycle).
REQ-018 SHALL give load-use priority over branch detection; a branch stalled by load-use re-evaluates next cycle.
REQ-019 SHALL, when no hazard and no freeze, drive all enables 1 and all other outputs 0.
REQ-020 SHALL ignore EX_br_resolved in RUN.

Reset
REQ-021 SHALL, while rst=0, force state RUN, wcnt 0, all enables 1, ST_br_stall/flush/bubble/mem_err 0, independent of clk.
REQ-022 SHALL abandon BR_WAIT or an in-progress memory wait on reset without any error pulse.

Configuration
REQ-023 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs ST_stall_cycles and ST_flush_cycles (16-bit, saturating at 0xFFFF, reset to 0) counting cycles with any enable 0, and cycles with flush or bubble asserted.
REQ-024 SHALL, without HAZARD_PERF_CNT_EN, omit those ports and counters entirely; other behaviour identical.

Structure
REQ-025 SHALL place FSM state enum (RUN, BR_WAIT) and MEM_TIMEOUT default in shared package hazard_pkg; `DONT_BRANCH, `TRUE remain in sys_defs.vh.
REQ-026 SHALL place the saturating counters in sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-027 SHALL cover reset: rst=0 mid-BR_WAIT -> state RUN, enables 1, ST_br_stall 0 immediately, before next clk.
REQ-028 SHALL cover load-use: EX_is_load=1, EX_rd=5, ID_rs2=5, ID_uses_rs2=1 -> one cycle ST_id_ex_bubble=1, ST_if_id_en=0; EX_rd=0 -> no stall.
REQ-029 SHALL cover branch: ID_mux_sel[11:9]!=`DONT_BRANCH, EX_br_resolved 2 cycles later -> ST_br_stall high 3 cycles, ST_if_id_flush high 2 cycles.
REQ-030 SHALL cover memory wait: MEM_req=1, MEM_ack low 3 cycles -> all enables 0 for 3 cycles, BR_WAIT held, resume on ack.
REQ-031 SHALL cover timeout: MEM_req=1, MEM_ack=0 forever, MEM_TIMEOUT=15 -> 15 freeze cycles, ST_mem_err pulse on cycle 16, enables 1.
REQ-032 SHALL cover HAZARD_PERF_CNT_EN: 20 freeze cycles -> ST_stall_cycles=20; forced 70000 -> 0xFFFF held.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e          : controller FSM states (RUN, BR_WAIT)
//   MEM_TIMEOUT_DEFAULT : default bound on consecutive data-memory wait cycles
//   WCNT_W              : width of the memory wait counter
// `DONT_BRANCH and `TRUE normally come from sys_defs.vh. The guarded
// fallbacks below keep this slice self-contained when that header is not
// part of the build; an existing definition always wins.
`ifndef DONT_BRANCH
`define DONT_BRANCH 3'b000
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif

package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } hz_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;
    localparam int unsigned WCNT_W              = 4;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall/flush cycle counters for the hazard controller.
// Only present when HAZARD_PERF_CNT_EN is defined; otherwise this file
// contributes nothing to the build.
//   clk, rst          : clock, asynchronous active-low reset
//   inc_stall         : this cycle had at least one pipeline enable low
//   inc_flush         : this cycle had a flush or bubble asserted
//   stall_cycles      : 16-bit saturating count of inc_stall cycles
//   flush_cycles      : 16-bit saturating count of inc_flush cycles
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_stall,
    input  logic        inc_flush,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            // Counters stick at all-ones instead of wrapping.
            if (inc_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (inc_flush && (flush_cycles != 16'hFFFF))
                flush_cycles <= flush_cycles + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch wait/flush and
// data-memory wait freeze with timeout.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds ST_stall_cycles and
// ST_flush_cycles, driven by hazard_perf_cnt).
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   ID_*                         : decoded controls / source operands in ID
//   EX_rd, EX_is_load            : destination and load flag in EX
//   EX_br_resolved               : branch in EX resolved this cycle
//   MEM_req, MEM_ack             : data-memory handshake of MEM stage
//   ST_*_en                      : pipeline register enables
//   ST_br_stall                  : hold PC
//   ST_if_id_flush               : load NOP into IF/ID
//   ST_id_ex_bubble              : load NOP into ID/EX
//   ST_mem_err                   : one-cycle pulse on memory timeout
//   dbg_state                    : current FSM state
// Memory handshake: MEM_req high with MEM_ack low means the access is still
// outstanding; the cycle MEM_ack is high the access completes.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ID_mux_sel,
    input  logic        ID_valid,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_is_load,
    input  logic        EX_br_resolved,
    input  logic        MEM_req,
    input  logic        MEM_ack,
    output logic        ST_if_id_en,
    output logic        ST_id_ex_en,
    output logic        ST_ex_mem_en,
    output logic        ST_mem_wb_en,
    output logic        ST_br_stall,
    output logic        ST_if_id_flush,
    output logic        ST_id_ex_bubble,
    output logic        ST_mem_err,
    output hz_state_e   dbg_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] ST_stall_cycles,
    output logic [15:0] ST_flush_cycles
`endif
);

    localparam logic [WCNT_W-1:0] TIMEOUT_LIM = WCNT_W'(MEM_TIMEOUT);

    hz_state_e         state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              mem_wait, freeze, timeout, load_use, id_branch;
    logic              unused_mux_bits;

    assign unused_mux_bits = ^ID_mux_sel[8:0];
    assign dbg_state       = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        mem_wait  = MEM_req & ~MEM_ack;
        freeze    = mem_wait & (wcnt < TIMEOUT_LIM);
        timeout   = mem_wait & (wcnt == TIMEOUT_LIM);
        load_use  = EX_is_load & (EX_rd != 5'd0) & ID_valid &
                    ((ID_uses_rs1 & (ID_rs1 == EX_rd)) |
                     (ID_uses_rs2 & (ID_rs2 == EX_rd)));
        id_branch = ID_valid & (ID_mux_sel[11:9] != `DONT_BRANCH);

        state_nxt       = state;
        wcnt_nxt        = '0;
        ST_if_id_en     = 1'b1;
        ST_id_ex_en     = 1'b1;
        ST_ex_mem_en    = 1'b1;
        ST_mem_wb_en    = 1'b1;
        ST_br_stall     = 1'b0;
        ST_if_id_flush  = 1'b0;
        ST_id_ex_bubble = 1'b0;
        ST_mem_err      = 1'b0;

        // Outputs must sit at their idle values for the whole reset
        // window, even while the inputs still describe a hazard.
        if (rst) begin
            if (freeze) begin
                ST_if_id_en  = 1'b0;
                ST_id_ex_en  = 1'b0;
                ST_ex_mem_en = 1'b0;
                ST_mem_wb_en = 1'b0;
                ST_br_stall  = 1'b1;
                wcnt_nxt     = wcnt + 1'b1;
            end else begin
                // A timed-out access releases the pipeline this cycle;
                // normal hazard handling proceeds alongside the error.
                ST_mem_err = timeout;
                unique case (state)
                    RUN: begin
                        if (load_use) begin
                            ST_if_id_en     = 1'b0;
                            ST_br_stall     = 1'b1;
                            ST_id_ex_bubble = 1'b1;
                        end else if (id_branch) begin
                            ST_br_stall = 1'b1;
                            state_nxt   = BR_WAIT;
                        end
                    end
                    BR_WAIT: begin
                        ST_br_stall    = 1'b1;
                        ST_if_id_flush = 1'b1;
                        if (EX_br_resolved)
                            state_nxt = RUN;
                    end
                    default: state_nxt = RUN;
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst          (rst),
        .inc_stall    (~(ST_if_id_en & ST_id_ex_en & ST_ex_mem_en & ST_mem_wb_en)),
        .inc_flush    (ST_if_id_flush | ST_id_ex_bubble),
        .stall_cycles (ST_stall_cycles),
        .flush_cycles (ST_flush_cycles)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Output vector layout used throughout:
// {if_id_en, id_ex_en, ex_mem_en, mem_wb_en, br_stall, if_id_flush,
//  id_ex_bubble, mem_err}.
`ifndef DONT_BRANCH
`define DONT_BRANCH 3'b000
`endif

module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int TMO = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ID_mux_sel;
    logic        ID_valid, ID_uses_rs1, ID_uses_rs2;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd;
    logic        EX_is_load, EX_br_resolved, MEM_req, MEM_ack;
    logic        ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en;
    logic        ST_br_stall, ST_if_id_flush, ST_id_ex_bubble, ST_mem_err;
    hz_state_e   dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] ST_stall_cycles, ST_flush_cycles;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ID_mux_sel(ID_mux_sel), .ID_valid(ID_valid),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_is_load(EX_is_load), .EX_br_resolved(EX_br_resolved),
        .MEM_req(MEM_req), .MEM_ack(MEM_ack),
        .ST_if_id_en(ST_if_id_en), .ST_id_ex_en(ST_id_ex_en),
        .ST_ex_mem_en(ST_ex_mem_en), .ST_mem_wb_en(ST_mem_wb_en),
        .ST_br_stall(ST_br_stall), .ST_if_id_flush(ST_if_id_flush),
        .ST_id_ex_bubble(ST_id_ex_bubble), .ST_mem_err(ST_mem_err),
        .dbg_state(dbg_state)
`ifdef HAZARD_PERF_CNT_EN
        , .ST_stall_cycles(ST_stall_cycles), .ST_flush_cycles(ST_flush_cycles)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // ---------------- reference model ----------------
    // Abstract view: "waiting for a branch" flag plus a count of how many
    // consecutive cycles memory has already been waited on.
    bit m_waiting_branch;
    int m_mem_waited;

    function automatic logic [7:0] got_vec();
        return {ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en,
                ST_br_stall, ST_if_id_flush, ST_id_ex_bubble, ST_mem_err};
    endfunction

    function automatic bit m_load_use();
        return EX_is_load && EX_rd != 0 && ID_valid &&
               ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
    endfunction

    function automatic bit m_mem_outstanding();
        return MEM_req && !MEM_ack;
    endfunction

    function automatic logic [7:0] model_expect();
        logic err;
        if (m_mem_outstanding() && m_mem_waited < TMO) return 8'b0000_1000;
        err = m_mem_outstanding();   // only reachable here on the timeout cycle
        if (m_waiting_branch) return {7'b1111_110, err};
        if (m_load_use())     return {7'b0111_101, err};
        if (ID_valid && ID_mux_sel[11:9] != `DONT_BRANCH) return {7'b1111_100, err};
        return {7'b1111_000, err};
    endfunction

    task automatic model_edge();
        if (m_mem_outstanding() && m_mem_waited < TMO) begin
            m_mem_waited++;
            return;
        end
        m_mem_waited = 0;
        if (m_waiting_branch) begin
            if (EX_br_resolved) m_waiting_branch = 0;
        end else if (!m_load_use() && ID_valid && ID_mux_sel[11:9] != `DONT_BRANCH) begin
            m_waiting_branch = 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ID_mux_sel = {`DONT_BRANCH, 9'h0}; ID_valid = 0;
        ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
        EX_rd = 0; EX_is_load = 0; EX_br_resolved = 0;
        MEM_req = 0; MEM_ack = 0;
    endtask

    task automatic model_reset();
        m_waiting_branch = 0;
        m_mem_waited     = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    // Samples outputs mid-cycle, records the model expectation, then
    // advances the model across the next rising edge.
    task automatic tick(input bit sb, output logic [7:0] got);
        @(negedge clk);
        got = got_vec();
        if (sb) exp_q.push_back(model_expect());
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input bit v);
        ID_valid   = v;
        ID_mux_sel = v ? {3'b010, 9'h155} : {`DONT_BRANCH, 9'h0};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] g;
        @(negedge clk);
        g = got_vec();
        n_cmp++;
        if (g !== 8'b1111_0000 || dbg_state !== RUN) begin
            n_err++; $display("FAIL reset_idle got=%b st=%0d exp=11110000 st=0", g, dbg_state);
        end
        @(posedge clk); #1;
        // Enter BR_WAIT, then assert reset asynchronously mid-cycle.
        set_branch(1);
        tick(0, g);
        set_branch(0);
        ID_valid = 1; ID_mux_sel = {3'b001, 9'h0};
        #2 rst = 0;
        model_reset();
        #1 g = got_vec();
        n_cmp++;
        if (g !== 8'b1111_0000 || dbg_state !== RUN) begin
            n_err++; $display("FAIL reset_async_brwait got=%b st=%0d exp=11110000 st=0", g, dbg_state);
        end
        idle_inputs();
        @(posedge clk); #1 rst = 1;
        // Reset during a memory wait: no error pulse, enables forced high.
        MEM_req = 1; MEM_ack = 0;
        repeat (5) tick(0, g);
        #2 rst = 0;
        model_reset();
        #1 g = got_vec();
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL reset_async_memwait got=%b exp=11110000", g);
        end
        @(negedge clk) g = got_vec();
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL reset_held_memwait got=%b exp=11110000", g);
        end
        idle_inputs();
        @(posedge clk); #1 rst = 1;
    endtask

    task automatic test_load_use();
        logic [7:0] g;
        EX_is_load = 1; EX_rd = 5; ID_valid = 1;
        ID_rs1 = 7; ID_rs2 = 5; ID_uses_rs1 = 1; ID_uses_rs2 = 1;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b0111_1010) begin
            n_err++; $display("FAIL load_use_rs2 got=%b exp=01111010", g);
        end
        EX_is_load = 0; EX_rd = 0;  // load has advanced
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL load_use_one_cycle got=%b exp=11110000", g);
        end
        EX_is_load = 1; EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL load_use_rd0 got=%b exp=11110000", g);
        end
        EX_rd = 9; ID_rs1 = 9; ID_uses_rs1 = 0; ID_rs2 = 3;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL load_use_unused_src got=%b exp=11110000", g);
        end
        // Load-use beats branch; branch re-evaluated next cycle.
        ID_uses_rs1 = 1; ID_mux_sel = {3'b011, 9'h0};
        tick(0, g);
        n_cmp++;
        if (g !== 8'b0111_1010) begin
            n_err++; $display("FAIL lu_over_branch got=%b exp=01111010", g);
        end
        EX_is_load = 0; EX_rd = 0;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_1000) begin
            n_err++; $display("FAIL branch_after_lu got=%b exp=11111000", g);
        end
        idle_inputs();
        EX_br_resolved = 1;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_1100) begin
            n_err++; $display("FAIL branch_after_lu_wait got=%b exp=11111100", g);
        end
        idle_inputs();
        tick(0, g);
    endtask

    task automatic test_branch();
        logic [7:0] g;
        int stalls = 0, flushes = 0;
        ID_valid = 1; ID_mux_sel = {`DONT_BRANCH, 9'h1FF};
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL no_branch_sel got=%b exp=11110000", g);
        end
        ID_valid = 0; ID_mux_sel = {3'b101, 9'h0};
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL branch_invalid got=%b exp=11110000", g);
        end
        for (int c = 0; c < 5; c++) begin
            set_branch(c == 0);
            EX_br_resolved = (c == 2);
            tick(0, g);
            stalls  += int'(g[3]);
            flushes += int'(g[2]);
        end
        n_cmp++;
        if (stalls != 3 || flushes != 2) begin
            n_err++; $display("FAIL branch_lengths got stall=%0d flush=%0d exp 3/2", stalls, flushes);
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        logic [7:0] g;
        set_branch(1);
        tick(0, g);
        set_branch(0);
        MEM_req = 1; MEM_ack = 0; EX_br_resolved = 1;
        for (int c = 0; c < 3; c++) begin
            tick(0, g);
            n_cmp++;
            if (g !== 8'b0000_1000 || dbg_state !== BR_WAIT) begin
                n_err++; $display("FAIL mem_freeze c%0d got=%b st=%0d exp=00001000 st=1", c, g, dbg_state);
            end
        end
        MEM_ack = 1; EX_br_resolved = 0;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_1100) begin
            n_err++; $display("FAIL mem_resume got=%b exp=11111100", g);
        end
        MEM_req = 0; MEM_ack = 0; EX_br_resolved = 1;
        tick(0, g);
        EX_br_resolved = 0;
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL mem_after_branch got=%b exp=11110000", g);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] g;
        int frozen = 0;
        MEM_req = 1; MEM_ack = 0;
        for (int c = 0; c < TMO; c++) begin
            tick(0, g);
            if (g === 8'b0000_1000) frozen++;
        end
        n_cmp++;
        if (frozen != TMO) begin
            n_err++; $display("FAIL timeout_freeze_len got=%0d exp=%0d", frozen, TMO);
        end
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0001) begin
            n_err++; $display("FAIL timeout_err_pulse got=%b exp=11110001", g);
        end
        tick(0, g);
        n_cmp++;
        if (g !== 8'b0000_1000) begin
            n_err++; $display("FAIL timeout_refreeze got=%b exp=00001000", g);
        end
        idle_inputs();
        tick(0, g);
        n_cmp++;
        if (g !== 8'b1111_0000) begin
            n_err++; $display("FAIL timeout_release got=%b exp=11110000", g);
        end
    endtask

    task automatic test_random();
        logic [7:0] g, e;
        int burst = 0;
        for (int c = 0; c < 600; c++) begin
            ID_mux_sel     = 12'($urandom);
            if ($urandom_range(0, 1) == 0) ID_mux_sel[11:9] = `DONT_BRANCH;
            ID_valid       = 1'($urandom_range(0, 3) != 0);
            ID_rs1         = 5'($urandom_range(0, 3));
            ID_rs2         = 5'($urandom_range(0, 3));
            ID_uses_rs1    = 1'($urandom);
            ID_uses_rs2    = 1'($urandom);
            EX_rd          = 5'($urandom_range(0, 3));
            EX_is_load     = 1'($urandom);
            EX_br_resolved = 1'($urandom_range(0, 2) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(12, 20);
            if (burst > 0) begin
                MEM_req = 1; MEM_ack = 0; burst--;
            end else begin
                MEM_req = 1'($urandom_range(0, 2) == 0);
                MEM_ack = 1'($urandom);
            end
            tick(1, g);
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++; $display("FAIL random c%0d got=%b exp=%b", c, g, e);
            end
        end
        idle_inputs();
        tick(0, g);
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [7:0] g;
        do_reset();
        MEM_req = 1;
        for (int c = 0; c < 21; c++) begin
            MEM_ack = (c == 10);
            tick(0, g);
        end
        idle_inputs();
        tick(0, g);
        n_cmp++;
        if (ST_stall_cycles !== 16'd20 || ST_flush_cycles !== 16'd0) begin
            n_err++; $display("FAIL perf_20 got stall=%0d flush=%0d exp 20/0", ST_stall_cycles, ST_flush_cycles);
        end
        EX_is_load = 1; EX_rd = 4; ID_valid = 1; ID_rs1 = 4; ID_uses_rs1 = 1;
        repeat (70000) tick(0, g);
        n_cmp++;
        if (ST_stall_cycles !== 16'hFFFF || ST_flush_cycles !== 16'hFFFF) begin
            n_err++; $display("FAIL perf_sat got stall=%h flush=%h exp ffff", ST_stall_cycles, ST_flush_cycles);
        end
        tick(0, g);
        n_cmp++;
        if (ST_stall_cycles !== 16'hFFFF) begin
            n_err++; $display("FAIL perf_sat_hold got=%h exp=ffff", ST_stall_cycles);
        end
        idle_inputs();
        tick(0, g);
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        do_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
